ck2ck_fifo_wr_arbiter: RTL and testbench

Round-robin write-side arbiter for the clock-to-clock FIFO: shares the FIFO push port between `NREQ` requesters in the FIFO's write clock domain. Grants one requester at a time for a bounded burst, forwards its data straight onto the FIFO push port under `fifoFull` back-pressure, and releases the grant on last-beat, burst limit or stall timeout. Sits directly in front of the FIFO write port, in the same clock domain.

---
 rtl/ck2ck_fifo_pkg.sv | 17 +
 rtl/ck2ck_fifo_wr_arbiter_rr_pick.sv | 38 +++
 rtl/ck2ck_fifo_wr_arbiter.sv | 122 ++++++++++++
 tb/tb_ck2ck_fifo_wr_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ck2ck_fifo_pkg.sv
// Shared typedefs and constants for the clock-to-clock FIFO and the blocks in front of it.
// The write-side arbiter state enum lives here next to the FIFO's own state typedefs.
package ck2ck_fifo_pkg;

  localparam int XFER_CNT_W = 16;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } ty_WrArbStates;

  // Index width for an n-entry vector. A single entry still gets one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ck2ck_fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request bit strictly after rr_ptr_i, wrapping.
// The write-side arbiter uses it today, and a future read-side scheduler can reuse it.
module rr_pick
  import ck2ck_fifo_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = id_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [ID_W-1:0] rr_ptr_i,
  output logic            any_req_o,
  output logic [ID_W-1:0] winner_o
);

  logic [ID_W:0] idx;
  logic          found;

  // NOTE: every output of a combinational block gets a default before any branch,
  // so that no path leaves a value unassigned and infers a latch.
  always_comb begin
    winner_o = '0;
    found    = 1'b0;
    idx      = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = {1'b0, rr_ptr_i} + (ID_W + 1)'(i);
      if (idx >= (ID_W + 1)'(NREQ)) begin
        idx = idx - (ID_W + 1)'(NREQ);
      end
      if (!found && req_i[idx[ID_W-1:0]]) begin
        found    = 1'b1;
        winner_o = idx[ID_W-1:0];
      end
    end
  end

  assign any_req_o = |req_i;

endmodule

// File: rtl/ck2ck_fifo_wr_arbiter.sv
// Round-robin write-side arbiter for the ck2ck FIFO. It grants one requester for a bounded burst
// and steers that requester's beats onto the FIFO push port, holding off while fifoFull is high.
module ck2ck_fifo_wr_arbiter
  import ck2ck_fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int NREQ      = 4,
  parameter int BURST_MAX = 4,
  parameter int STALL_MAX = 8
) (
  input  logic                       ck,
  input  logic                       srstN,
  input  logic                       enable,
  input  logic [NREQ-1:0]            reqValid,
  input  logic [NREQ*DATA_W-1:0]     reqData,
  input  logic [NREQ-1:0]            reqLast,
  output logic [NREQ-1:0]            reqReady,
  output logic                       fifoPush,
  output logic [DATA_W-1:0]          fifoData,
  input  logic                       fifoFull,
  output logic                       grantValid,
  output logic [$clog2(NREQ)-1:0]    grantId,
  output logic [XFER_CNT_W-1:0]      xferCount
);

  localparam int ID_W   = $clog2(NREQ);
  localparam int BCNT_W = $clog2(BURST_MAX + 1);
  localparam int SCNT_W = $clog2(STALL_MAX + 1);

  ty_WrArbStates          state_q;
  logic [ID_W-1:0]        grant_id_q;
  logic [ID_W-1:0]        rr_ptr_q;
  logic [BCNT_W-1:0]      burst_cnt_q;
  logic [SCNT_W-1:0]      stall_cnt_q;
  logic [XFER_CNT_W-1:0]  xfer_cnt_q;

  logic                   any_req;
  logic [ID_W-1:0]        winner;
  logic                   in_burst;
  logic                   gnt_valid;
  logic                   beat_ok;
  logic                   xfer;
  logic                   burst_done;
  logic                   stall_done;
  logic                   release_gnt;
  logic [DATA_W-1:0]      req_data_arr [NREQ];

  rr_pick #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_rr_pick (
    .req_i     (reqValid),
    .rr_ptr_i  (rr_ptr_q),
    .any_req_o (any_req),
    .winner_o  (winner)
  );

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign req_data_arr[g] = reqData[g*DATA_W +: DATA_W];
  end

  // srstN also gates the push port, so no beat leaves in the cycle a reset is applied.
  assign in_burst    = (state_q == ST_BURST);
  assign gnt_valid   = reqValid[grant_id_q];
  assign beat_ok     = in_burst & srstN & ~fifoFull;
  assign xfer        = beat_ok & gnt_valid;
  assign burst_done  = (burst_cnt_q == BCNT_W'(BURST_MAX - 1));
  assign stall_done  = (stall_cnt_q == SCNT_W'(STALL_MAX - 1));
  assign release_gnt = (xfer & (reqLast[grant_id_q] | burst_done))
                     | (in_burst & ~gnt_valid & stall_done);

  always_comb begin
    reqReady             = '0;
    reqReady[grant_id_q] = beat_ok;
  end

  assign fifoPush   = xfer;
  assign fifoData   = req_data_arr[grant_id_q];
  assign grantValid = in_burst;
  assign grantId    = grant_id_q;
  assign xferCount  = xfer_cnt_q;

  // NOTE: state is updated only with non-blocking assignments, so every register
  // samples the values from before the edge no matter what order the statements are in.
  always_ff @(posedge ck) begin
    if (!srstN) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= ID_W'(NREQ - 1);
      grant_id_q  <= '0;
      burst_cnt_q <= '0;
      stall_cnt_q <= '0;
      xfer_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable && any_req) begin
            state_q     <= ST_BURST;
            grant_id_q  <= winner;
            burst_cnt_q <= '0;
            stall_cnt_q <= '0;
          end
        end
        ST_BURST: begin
          // Back-pressure with valid held high is not idleness, so it leaves stall_cnt alone.
          if (xfer) begin
            burst_cnt_q <= burst_cnt_q + BCNT_W'(1);
            xfer_cnt_q  <= xfer_cnt_q + XFER_CNT_W'(1);
            stall_cnt_q <= '0;
          end else if (!gnt_valid) begin
            stall_cnt_q <= stall_cnt_q + SCNT_W'(1);
          end
          if (release_gnt) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= grant_id_q;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ck2ck_fifo_wr_arbiter.sv
// Self-checking bench for ck2ck_fifo_wr_arbiter: a cycle table for the basic packet, then
// hand-written sequences for round-robin, back-pressure, stall timeout, reset and enable.
module tb_ck2ck_fifo_wr_arbiter;

  localparam int DATA_W    = 8;
  localparam int NREQ      = 4;
  localparam int BURST_MAX = 4;
  localparam int STALL_MAX = 8;

  logic                   ck = 1'b0;
  logic                   srstN;
  logic                   enable;
  logic [NREQ-1:0]        reqValid;
  logic [NREQ*DATA_W-1:0] reqData;
  logic [NREQ-1:0]        reqLast;
  logic [NREQ-1:0]        reqReady;
  logic                   fifoPush;
  logic [DATA_W-1:0]      fifoData;
  logic                   fifoFull;
  logic                   grantValid;
  logic [1:0]             grantId;
  logic [15:0]            xferCount;

  logic [7:0] rd [NREQ];
  assign reqData = {rd[3], rd[2], rd[1], rd[0]};

  ck2ck_fifo_wr_arbiter #(
    .DATA_W    (DATA_W),
    .NREQ      (NREQ),
    .BURST_MAX (BURST_MAX),
    .STALL_MAX (STALL_MAX)
  ) dut (
    .ck         (ck),
    .srstN      (srstN),
    .enable     (enable),
    .reqValid   (reqValid),
    .reqData    (reqData),
    .reqLast    (reqLast),
    .reqReady   (reqReady),
    .fifoPush   (fifoPush),
    .fifoData   (fifoData),
    .fifoFull   (fifoFull),
    .grantValid (grantValid),
    .grantId    (grantId),
    .xferCount  (xferCount)
  );

  always #5 ck = ~ck;

  int checks   = 0;
  int failures = 0;

  // Source model: requester i offers base[i] + beats accepted so far, reqLast when sent[i] == last_at[i].
  logic       auto_data;
  logic       mon_en;
  logic [7:0] base    [NREQ];
  int         sent    [NREQ];
  int         last_at [NREQ];
  int         exp_cnt [NREQ];

  logic [7:0] exp_q [$];
  int         glog  [$];
  logic       prev_gv;

  // Outputs as sampled on the falling edge of the latest cycle.
  logic        s_gv, s_push;
  logic [1:0]  s_gid;
  logic [7:0]  s_data;
  logic [3:0]  s_ready;
  logic [15:0] s_xcnt;

  typedef struct {
    logic        en;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [7:0]  d2;
    logic        full;
    logic        gv;
    logic [1:0]  gid;
    logic        push;
    logic [7:0]  data;
    logic [3:0]  ready;
    logic [15:0] xcnt;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_beat(input int id);
    exp_q.push_back(base[id] + 8'(exp_cnt[id]));
    exp_cnt[id]++;
  endtask

  // One clock cycle: drive source data, sample at the falling edge, score pushes, return just after the rising edge.
  task automatic cyc();
    logic [7:0] e;
    if (auto_data) begin
      for (int i = 0; i < NREQ; i++) begin
        rd[i]      = base[i] + 8'(sent[i]);
        reqLast[i] = (sent[i] == last_at[i]);
      end
    end
    @(negedge ck);
    s_gv    = grantValid;
    s_gid   = grantId;
    s_push  = fifoPush;
    s_data  = fifoData;
    s_ready = reqReady;
    s_xcnt  = xferCount;
    if (mon_en) begin
      check("ready_onehot0", 32'($onehot0(reqReady)), 32'd1);
      if (fifoFull) check("no_push_when_full", 32'(fifoPush), 32'd0);
      if (fifoPush === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_push: actual=0x%0h required=no push", fifoData);
        end else begin
          e = exp_q.pop_front();
          check("push_data", 32'(fifoData), 32'(e));
        end
      end
      if (grantValid && !prev_gv) glog.push_back(int'(grantId));
      prev_gv = grantValid;
      for (int i = 0; i < NREQ; i++) begin
        if (reqValid[i] && reqReady[i]) sent[i]++;
      end
    end
    @(posedge ck);
    #1;
  endtask

  task automatic do_reset();
    srstN     = 1'b0;
    enable    = 1'b0;
    reqValid  = '0;
    reqLast   = '0;
    fifoFull  = 1'b0;
    auto_data = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      rd[i]      = '0;
      base[i]    = '0;
      sent[i]    = 0;
      exp_cnt[i] = 0;
      last_at[i] = -1;
    end
    cyc();
    cyc();
    check("rst_grantValid", 32'(s_gv), 32'd0);
    check("rst_grantId", 32'(s_gid), 32'd0);
    check("rst_fifoPush", 32'(s_push), 32'd0);
    check("rst_reqReady", 32'(s_ready), 32'd0);
    check("rst_xferCount", 32'(s_xcnt), 32'd0);
    srstN = 1'b1;
    exp_q.delete();
    glog.delete();
    prev_gv = 1'b0;
  endtask

  initial begin
    int exp_order [5];
    logic ep, eg;

    mon_en  = 1'b0;
    prev_gv = 1'b0;

    vecs[0] = '{1'b1, 4'b0100, 4'b0000, 8'hA1, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000, 16'd0};
    vecs[1] = '{1'b1, 4'b0100, 4'b0000, 8'hA1, 1'b0, 1'b1, 2'd2, 1'b1, 8'hA1, 4'b0100, 16'd0};
    vecs[2] = '{1'b1, 4'b0100, 4'b0000, 8'hA2, 1'b0, 1'b1, 2'd2, 1'b1, 8'hA2, 4'b0100, 16'd1};
    vecs[3] = '{1'b1, 4'b0100, 4'b0100, 8'hA3, 1'b0, 1'b1, 2'd2, 1'b1, 8'hA3, 4'b0100, 16'd2};
    vecs[4] = '{1'b1, 4'b0000, 4'b0000, 8'h00, 1'b0, 1'b0, 2'd2, 1'b0, 8'h00, 4'b0000, 16'd3};
    vecs[5] = '{1'b1, 4'b0000, 4'b0000, 8'h00, 1'b0, 1'b0, 2'd2, 1'b0, 8'h00, 4'b0000, 16'd3};

    // Single requester, three-beat packet.
    do_reset();
    mon_en = 1'b1;
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'hA2);
    exp_q.push_back(8'hA3);
    for (int r = 0; r < 6; r++) begin
      enable   = vecs[r].en;
      reqValid = vecs[r].valid;
      reqLast  = vecs[r].last;
      rd[2]    = vecs[r].d2;
      fifoFull = vecs[r].full;
      cyc();
      check($sformatf("t1_r%0d_gv", r), 32'(s_gv), 32'(vecs[r].gv));
      check($sformatf("t1_r%0d_gid", r), 32'(s_gid), 32'(vecs[r].gid));
      check($sformatf("t1_r%0d_push", r), 32'(s_push), 32'(vecs[r].push));
      check($sformatf("t1_r%0d_ready", r), 32'(s_ready), 32'(vecs[r].ready));
      check($sformatf("t1_r%0d_xcnt", r), 32'(s_xcnt), 32'(vecs[r].xcnt));
      if (vecs[r].push) check($sformatf("t1_r%0d_data", r), 32'(s_data), 32'(vecs[r].data));
    end
    check("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // All requesters valid, no reqLast: bursts of BURST_MAX in order 0,1,2,3,0 with one bubble each.
    do_reset();
    enable    = 1'b1;
    auto_data = 1'b1;
    base[0] = 8'h10; base[1] = 8'h20; base[2] = 8'h30; base[3] = 8'h40;
    exp_order = '{0, 1, 2, 3, 0};
    for (int g = 0; g < 5; g++) begin
      for (int b = 0; b < BURST_MAX; b++) expect_beat(exp_order[g]);
    end
    reqValid = 4'b1111;
    for (int c = 0; c < 25; c++) begin
      cyc();
      ep = (c >= 1) && (((c - 1) % 5) < 4);
      check($sformatf("t2_c%0d_push", c), 32'(s_push), 32'(ep));
    end
    check("t2_xcnt", 32'(s_xcnt), 32'd19);
    check("t2_grants", 32'(glog.size()), 32'd5);
    for (int k = 0; k < 5 && k < glog.size(); k++) begin
      check($sformatf("t2_grant%0d", k), 32'(glog[k]), 32'(exp_order[k]));
    end
    check("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // fifoFull held for 10 cycles mid-burst; reqLast lands on the BURST_MAX-th beat.
    do_reset();
    enable     = 1'b1;
    auto_data  = 1'b1;
    base[0]    = 8'h50;
    last_at[0] = 3;
    for (int b = 0; b < 4; b++) expect_beat(0);
    reqValid = 4'b0001;
    for (int c = 0; c < 16; c++) begin
      fifoFull = (c >= 3) && (c <= 12);
      cyc();
      ep = (c == 1) || (c == 2) || (c == 13) || (c == 14);
      eg = (c >= 1) && (c <= 14);
      check($sformatf("t3_c%0d_push", c), 32'(s_push), 32'(ep));
      check($sformatf("t3_c%0d_gv", c), 32'(s_gv), 32'(eg));
      check($sformatf("t3_c%0d_ready", c), 32'(s_ready), 32'({3'b000, eg & ~fifoFull}));
    end
    check("t3_xcnt", 32'(s_xcnt), 32'd4);
    check("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // Stall timeout: 3 idle cycles, one beat (clears the count), then 8 idle cycles force release.
    do_reset();
    enable    = 1'b1;
    auto_data = 1'b1;
    base[0] = 8'h60; base[1] = 8'h70;
    expect_beat(0); expect_beat(0); expect_beat(1);
    for (int c = 0; c < 16; c++) begin
      reqValid = {2'b00, 1'b1, (c <= 1) || (c == 5)};
      cyc();
      ep = (c == 1) || (c == 5) || (c == 15);
      eg = ((c >= 1) && (c <= 13)) || (c == 15);
      check($sformatf("t4_c%0d_push", c), 32'(s_push), 32'(ep));
      check($sformatf("t4_c%0d_gv", c), 32'(s_gv), 32'(eg));
    end
    check("t4_gid_next", 32'(s_gid), 32'd1);
    check("t4_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset after two beats of requester 2's burst; first grant afterwards goes to requester 0.
    do_reset();
    enable    = 1'b1;
    auto_data = 1'b1;
    base[2] = 8'h80; base[0] = 8'h90;
    expect_beat(2); expect_beat(2); expect_beat(0);
    reqValid = 4'b0100;
    cyc();
    cyc();
    check("t5_beat1", 32'(s_push), 32'd1);
    cyc();
    check("t5_beat2", 32'(s_push), 32'd1);
    srstN = 1'b0;
    cyc();
    check("t5_rstcyc_push", 32'(s_push), 32'd0);
    check("t5_rstcyc_ready", 32'(s_ready), 32'd0);
    srstN    = 1'b1;
    reqValid = 4'b1111;
    cyc();
    check("t5_after_gv", 32'(s_gv), 32'd0);
    check("t5_after_push", 32'(s_push), 32'd0);
    check("t5_after_xcnt", 32'(s_xcnt), 32'd0);
    cyc();
    check("t5_regrant_gv", 32'(s_gv), 32'd1);
    check("t5_regrant_gid", 32'(s_gid), 32'd0);
    check("t5_sb_empty", 32'(exp_q.size()), 32'd0);

    // enable drops during a burst: the burst completes, no new grant until enable rises.
    do_reset();
    auto_data = 1'b1;
    base[0] = 8'hA0; base[1] = 8'hB0;
    for (int b = 0; b < 4; b++) expect_beat(0);
    expect_beat(1);
    reqValid = 4'b0011;
    for (int c = 0; c < 10; c++) begin
      enable = (c == 0) || (c >= 8);
      cyc();
      ep = ((c >= 1) && (c <= 4)) || (c == 9);
      check($sformatf("t6_c%0d_push", c), 32'(s_push), 32'(ep));
      check($sformatf("t6_c%0d_gv", c), 32'(s_gv), 32'(ep));
    end
    check("t6_gid_after_enable", 32'(s_gid), 32'd1);
    check("t6_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
